core_seq_ctrl: RTL

//  Multi-cycle instruction sequencer for the RV32E core. Drives fetch/load-store handshakes and latches the fetched instruction.

---
 rtl/core_ctrl_pkg.sv | 28 ++
 rtl/resp_watchdog.sv | 29 ++
 rtl/core_seq_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the RV32E instruction sequencer.
package core_ctrl_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned TRAP_W = 3;
    localparam int unsigned WDOG_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_REQ  = 3'd1,
        ST_F_WAIT = 3'd2,
        ST_DEC    = 3'd3,
        ST_M_REQ  = 3'd4,
        ST_M_WAIT = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    typedef enum logic [TRAP_W-1:0] {
        TRAP_NONE    = 3'd0,
        TRAP_EBREAK  = 3'd1,
        TRAP_ILLEGAL = 3'd2,
        TRAP_IFU_ERR = 3'd3,
        TRAP_LSU_ERR = 3'd4,
        TRAP_TIMEOUT = 3'd5
    } trap_e;

endpackage

// File: rtl/resp_watchdog.sv
// Response watchdog: counts cycles spent waiting and flags expiry on the TIMEOUT-th one.
module resp_watchdog
    import core_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [WDOG_W-1:0] cnt_q;

    // Wait-cycle counter; held at the expiry value so it never wraps
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired_c) begin
            cnt_q <= cnt_q + WDOG_W'(1);
        end
    end

    assign expired_c = enable && (cnt_q == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch/load-store handshakes, retire pulses, traps, counters.
module core_seq_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              run_en,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    input  logic              ifu_rsp_valid,
    input  logic              ifu_rsp_err,
    input  logic [INST_W-1:0] ifu_rsp_inst,
    output logic [INST_W-1:0] inst,
    input  logic              dec_ld,
    input  logic              dec_st,
    input  logic              dec_rd_wen,
    input  logic              dec_redirect,
    input  logic              dec_ebreak,
    input  logic              dec_illegal,
    output logic              lsu_req_valid,
    input  logic              lsu_req_ready,
    input  logic              lsu_rsp_valid,
    input  logic              lsu_rsp_err,
    output logic              gpr_wen,
    output logic              pc_wen,
    output logic              commit,
    output logic              halt,
    output logic [TRAP_W-1:0] trap_cause,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    state_e state_q;
    state_e state_d;
    trap_e  trap_d;

    logic ifu_exp_c;
    logic lsu_exp_c;
    logic ifu_wdog_clr;
    logic ifu_wdog_en;
    logic lsu_wdog_clr;
    logic lsu_wdog_en;

    logic ifu_req_valid_d;
    logic lsu_req_valid_d;
    logic commit_d;
    logic gpr_wen_d;
    logic pc_wen_d;
    logic halt_d;

    // Watchdogs restart while the request is pending and run only in the wait state
    assign ifu_wdog_clr = (state_q == ST_F_REQ);
    assign ifu_wdog_en  = (state_q == ST_F_WAIT);
    assign lsu_wdog_clr = (state_q == ST_M_REQ);
    assign lsu_wdog_en  = (state_q == ST_M_WAIT);

    resp_watchdog #(.TIMEOUT(TIMEOUT)) u_ifu_wdog (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (ifu_wdog_clr),
        .enable    (ifu_wdog_en),
        .expired_c (ifu_exp_c)
    );

    resp_watchdog #(.TIMEOUT(TIMEOUT)) u_lsu_wdog (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (lsu_wdog_clr),
        .enable    (lsu_wdog_en),
        .expired_c (lsu_exp_c)
    );

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and trap-cause selection; a response beats a same-cycle watchdog expiry
    always_comb begin
        state_d = state_q;
        trap_d  = TRAP_NONE;
        case (state_q)
            ST_IDLE:   if (run_en) state_d = ST_F_REQ;
            ST_F_REQ:  if (ifu_req_ready) state_d = ST_F_WAIT;
            ST_F_WAIT: begin
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        state_d = ST_HALT;
                        trap_d  = TRAP_IFU_ERR;
                    end else begin
                        state_d = ST_DEC;
                    end
                end else if (ifu_exp_c) begin
                    state_d = ST_HALT;
                    trap_d  = TRAP_TIMEOUT;
                end
            end
            ST_DEC: begin
                if (dec_illegal) begin
                    state_d = ST_HALT;
                    trap_d  = TRAP_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_d = ST_HALT;
                    trap_d  = TRAP_EBREAK;
                end else if (dec_ld || dec_st) begin
                    state_d = ST_M_REQ;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_M_REQ:  if (lsu_req_ready) state_d = ST_M_WAIT;
            ST_M_WAIT: begin
                if (lsu_rsp_valid) begin
                    if (lsu_rsp_err) begin
                        state_d = ST_HALT;
                        trap_d  = TRAP_LSU_ERR;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (lsu_exp_c) begin
                    state_d = ST_HALT;
                    trap_d  = TRAP_TIMEOUT;
                end
            end
            ST_WB:     state_d = run_en ? ST_F_REQ : ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so outputs track the state
    always_comb begin
        ifu_req_valid_d = (state_d == ST_F_REQ);
        lsu_req_valid_d = (state_d == ST_M_REQ);
        commit_d        = (state_d == ST_WB);
        gpr_wen_d       = commit_d && dec_rd_wen && !dec_st;
        pc_wen_d        = commit_d && dec_redirect;
        halt_d          = (state_d == ST_HALT);
    end

    // Output, instruction latch, trap and counter registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ifu_req_valid <= 1'b0;
            lsu_req_valid <= 1'b0;
            commit        <= 1'b0;
            gpr_wen       <= 1'b0;
            pc_wen        <= 1'b0;
            halt          <= 1'b0;
            inst          <= '0;
            trap_cause    <= '0;
            cycle_cnt     <= '0;
            instret_cnt   <= '0;
        end else begin
            ifu_req_valid <= ifu_req_valid_d;
            lsu_req_valid <= lsu_req_valid_d;
            commit        <= commit_d;
            gpr_wen       <= gpr_wen_d;
            pc_wen        <= pc_wen_d;
            halt          <= halt_d;
            if (state_q == ST_F_WAIT && ifu_rsp_valid && !ifu_rsp_err) begin
                inst <= ifu_rsp_inst;
            end
            if (state_d == ST_HALT && state_q != ST_HALT) begin
                trap_cause <= trap_d;
            end
            if (state_q != ST_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (state_q == ST_WB) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

endmodule
